// File: rtl/pipe_ctrl_seg_pkg.sv
// Shared constants for the pipeline control segment chain: counter width,
// depth bound and bit positions of the standard control vector.
package pipe_ctrl_seg_pkg;
   localparam int CNT_W           = 32;
   localparam int DEPTH_MAX       = 8;
   localparam int REG_WRITE_EN    = 0;
   localparam int CSRREG_WRITE_EN = 1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && v != {CNT_W{1'b1}}) ? v + 1'b1 : v;
   endfunction
endpackage

// File: rtl/pipe_ctrl_seg_stage.sv
// One control segment register: W-bit control vector plus valid bit with
// hold > flush > auto-bubble > advance priority.
module pipe_ctrl_stage
   import pipe_ctrl_seg_pkg::*;
#(
   parameter int           W         = 2,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         flush,
   input  logic         up_hold,
   input  logic [W-1:0] ctrl_i,
   input  logic         vld_i,
   output logic [W-1:0] ctrl_o,
   output logic         vld_o
);
   logic [W-1:0] ctrl_d, ctrl_q;
   logic         vld_d, vld_q;

   // A held upstream stage must not be copied forward, so it injects a bubble.
   always_comb begin
      ctrl_d = ctrl_q;
      vld_d  = vld_q;
      if (!hold) begin
         if (flush || up_hold) begin
            ctrl_d = RESET_VAL;
            vld_d  = 1'b0;
         end else begin
            ctrl_d = ctrl_i;
            vld_d  = vld_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= RESET_VAL;
         vld_q  <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         vld_q  <= vld_d;
      end
   end

   assign ctrl_o = ctrl_q;
   assign vld_o  = vld_q;
endmodule

// File: rtl/pipe_ctrl_seg.sv
// DEPTH-stage control segment chain with backward hold propagation.
// Optional perf counters enabled by PIPE_CTRL_SEG_PERF_EN.
module pipe_ctrl_seg
   import pipe_ctrl_seg_pkg::*;
#(
   parameter int           W         = 2,
   parameter int           DEPTH     = 1,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] bubble,
   input  logic [DEPTH-1:0] flush,
   input  logic [W-1:0]     ctrl_in,
   input  logic             valid_in,
   output logic [W-1:0]     ctrl_out,
   output logic             valid_out,
   output logic [DEPTH-1:0] stage_valid,
   output logic [DEPTH-1:0] held,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] hold_cnt
);
   logic [DEPTH-1:0][W-1:0] st_ctrl;
   logic [DEPTH-1:0]        st_vld;
   logic [DEPTH-1:0]        hold_c;

   // A stall anywhere downstream freezes every stage in front of it.
   always_comb begin
      hold_c = '0;
      hold_c[DEPTH-1] = bubble[DEPTH-1];
      for (int i = DEPTH-2; i >= 0; i--)
         hold_c[i] = bubble[i] | hold_c[i+1];
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         pipe_ctrl_stage #(.W(W), .RESET_VAL(RESET_VAL)) u_stage (
            .clk(clk), .rst(rst), .hold(hold_c[g]), .flush(flush[g]),
            .up_hold(1'b0), .ctrl_i(ctrl_in), .vld_i(valid_in),
            .ctrl_o(st_ctrl[g]), .vld_o(st_vld[g]));
      end else begin : g_body
         pipe_ctrl_stage #(.W(W), .RESET_VAL(RESET_VAL)) u_stage (
            .clk(clk), .rst(rst), .hold(hold_c[g]), .flush(flush[g]),
            .up_hold(hold_c[g-1]), .ctrl_i(st_ctrl[g-1]), .vld_i(st_vld[g-1]),
            .ctrl_o(st_ctrl[g]), .vld_o(st_vld[g]));
      end
   end

   assign ctrl_out    = st_ctrl[DEPTH-1];
   assign valid_out   = st_vld[DEPTH-1];
   assign stage_valid = st_vld;
   assign held        = hold_c;

`ifdef PIPE_CTRL_SEG_PERF_EN
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q, hold_cnt_d, hold_cnt_q;

   always_comb begin
      flush_cnt_d = sat_inc(flush_cnt_q, flush[DEPTH-1] & ~hold_c[DEPTH-1]);
      hold_cnt_d  = sat_inc(hold_cnt_q, hold_c[DEPTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt_q <= '0;
         hold_cnt_q  <= '0;
      end else begin
         flush_cnt_q <= flush_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign flush_cnt = flush_cnt_q;
   assign hold_cnt  = hold_cnt_q;
`else
   assign flush_cnt = '0;
   assign hold_cnt  = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl_seg.sv
// Bench for pipe_ctrl_seg: vector table, legacy DEPTH=1 sequence and
// randomized traffic against a stage-array reference model.
module tb_pipe_ctrl_seg;
   localparam int W = 8;
   localparam int D = 3;
   localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [D-1:0] bubble, flush, stage_valid, held;
   logic [W-1:0] ctrl_in, ctrl_out;
   logic         valid_in, valid_out;
   logic [31:0]  flush_cnt, hold_cnt;

   logic         b_rst, b_bub, b_fl, b_vin, b_vout, b_sv, b_held;
   logic [1:0]   b_cin, b_cout;
   logic [31:0]  b_fcnt, b_hcnt;

   pipe_ctrl_seg #(.W(W), .DEPTH(D), .RESET_VAL('0)) u3 (
      .clk(clk), .rst(rst), .bubble(bubble), .flush(flush), .ctrl_in(ctrl_in),
      .valid_in(valid_in), .ctrl_out(ctrl_out), .valid_out(valid_out),
      .stage_valid(stage_valid), .held(held), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt));

   pipe_ctrl_seg #(.W(2), .DEPTH(1), .RESET_VAL(2'b01)) u1 (
      .clk(clk), .rst(b_rst), .bubble(b_bub), .flush(b_fl), .ctrl_in(b_cin),
      .valid_in(b_vin), .ctrl_out(b_cout), .valid_out(b_vout),
      .stage_valid(b_sv), .held(b_held), .flush_cnt(b_fcnt), .hold_cnt(b_hcnt));

   int checks = 0;
   int errors = 0;

   // Reference model: array of stage contents plus perf counts.
   logic [W-1:0] m_ctrl[D];
   logic         m_vld[D];
   longint       m_hc, m_fc;
   logic [D-1:0] h_smp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [D-1:0] m_hold(input logic [D-1:0] b);
      logic [D-1:0] h;
      for (int i = 0; i < D; i++) h[i] = |(b >> i);
      return h;
   endfunction

   task automatic model_step(input logic r, input logic [D-1:0] b, f,
                             input logic [W-1:0] c, input logic v);
      logic [D-1:0] h;
      if (r) begin
         for (int i = 0; i < D; i++) begin m_ctrl[i] = '0; m_vld[i] = 1'b0; end
         m_hc = 0; m_fc = 0;
      end else begin
         h = m_hold(b);
         if (h[D-1] && m_hc < SAT) m_hc++;
         if (!h[D-1] && f[D-1] && m_fc < SAT) m_fc++;
         for (int i = D-1; i >= 0; i--) begin
            if (h[i]) ;
            else if (f[i] || (i > 0 && h[i-1])) begin m_ctrl[i] = '0; m_vld[i] = 1'b0; end
            else if (i == 0) begin m_ctrl[0] = c; m_vld[0] = v; end
            else begin m_ctrl[i] = m_ctrl[i-1]; m_vld[i] = m_vld[i-1]; end
         end
      end
   endtask

   task automatic cmp_model();
      logic [D-1:0] sv;
      for (int i = 0; i < D; i++) sv[i] = m_vld[i];
      chk("ctrl_out", ctrl_out, m_ctrl[D-1]);
      chk("valid_out", valid_out, m_vld[D-1]);
      chk("stage_valid", stage_valid, sv);
`ifdef PIPE_CTRL_SEG_PERF_EN
      chk("hold_cnt", hold_cnt, m_hc);
      chk("flush_cnt", flush_cnt, m_fc);
`else
      chk("hold_cnt", hold_cnt, 0);
      chk("flush_cnt", flush_cnt, 0);
`endif
   endtask

   task automatic cyc(input logic r, input logic [D-1:0] b, f,
                      input logic [W-1:0] c, input logic v);
      rst = r; bubble = b; flush = f; ctrl_in = c; valid_in = v;
      #1;
      h_smp = held;
      chk("held", held, m_hold(b));
      @(posedge clk);
      model_step(r, b, f, c, v);
      #1;
      cmp_model();
   endtask

   task automatic bcyc(input logic r, bb, bf, input logic [1:0] c, input logic v,
                       input logic [1:0] ec, input logic ev);
      b_rst = r; b_bub = bb; b_fl = bf; b_cin = c; b_vin = v;
      #1;
      chk("legacy_held", b_held, bb);
      @(posedge clk);
      #1;
      chk("legacy_ctrl", b_cout, ec);
      chk("legacy_valid", b_vout, ev);
      chk("legacy_sv", b_sv, ev);
   endtask

   typedef struct {
      logic [D-1:0] b, f;
      logic [W-1:0] c;
      logic         v;
      logic [D-1:0] eh, esv;
      logic [W-1:0] eo;
      logic         eov;
   } vec_t;
   vec_t tbl[12];

   initial begin
      tbl[0]  = '{3'b000, 3'b000, 8'h03, 1'b1, 3'b000, 3'b001, 8'h00, 1'b0};
      tbl[1]  = '{3'b000, 3'b000, 8'h0B, 1'b1, 3'b000, 3'b011, 8'h00, 1'b0};
      tbl[2]  = '{3'b000, 3'b000, 8'h0C, 1'b1, 3'b000, 3'b111, 8'h03, 1'b1};
      tbl[3]  = '{3'b000, 3'b010, 8'h0D, 1'b1, 3'b000, 3'b101, 8'h0B, 1'b1};
      tbl[4]  = '{3'b000, 3'b000, 8'h00, 1'b0, 3'b000, 3'b010, 8'h00, 1'b0};
      tbl[5]  = '{3'b010, 3'b000, 8'h0E, 1'b1, 3'b011, 3'b010, 8'h00, 1'b0};
      tbl[6]  = '{3'b010, 3'b000, 8'h0E, 1'b1, 3'b011, 3'b010, 8'h00, 1'b0};
      tbl[7]  = '{3'b000, 3'b000, 8'h0E, 1'b1, 3'b000, 3'b101, 8'h0D, 1'b1};
      tbl[8]  = '{3'b001, 3'b001, 8'h0F, 1'b1, 3'b001, 3'b001, 8'h00, 1'b0};
      tbl[9]  = '{3'b100, 3'b111, 8'h0F, 1'b1, 3'b111, 3'b001, 8'h00, 1'b0};
      tbl[10] = '{3'b000, 3'b100, 8'h0F, 1'b1, 3'b000, 3'b011, 8'h00, 1'b0};
      tbl[11] = '{3'b000, 3'b000, 8'h00, 1'b0, 3'b000, 3'b110, 8'h0E, 1'b1};

      b_rst = 1'b1; b_bub = 1'b0; b_fl = 1'b0; b_cin = 2'b00; b_vin = 1'b0;
      model_step(1'b1, '0, '0, '0, 1'b0);

      // Reset for two cycles: everything cleared.
      cyc(1'b1, 3'b000, 3'b000, 8'hFF, 1'b1);
      cyc(1'b1, 3'b000, 3'b000, 8'hFF, 1'b1);
      chk("rst_sv", stage_valid, 3'b000);
      chk("rst_out", ctrl_out, 8'h00);

      for (int k = 0; k < 12; k++) begin
         cyc(1'b0, tbl[k].b, tbl[k].f, tbl[k].c, tbl[k].v);
         chk($sformatf("tbl%0d_held", k), h_smp, tbl[k].eh);
         chk($sformatf("tbl%0d_sv", k), stage_valid, tbl[k].esv);
         chk($sformatf("tbl%0d_out", k), ctrl_out, tbl[k].eo);
         chk($sformatf("tbl%0d_vout", k), valid_out, tbl[k].eov);
      end

      // Reset while every stage is stalled.
      cyc(1'b0, 3'b000, 3'b000, 8'h21, 1'b1);
      cyc(1'b0, 3'b000, 3'b000, 8'h22, 1'b1);
      cyc(1'b0, 3'b111, 3'b000, 8'h23, 1'b1);
      cyc(1'b1, 3'b111, 3'b111, 8'h24, 1'b1);
      chk("rst_stall_sv", stage_valid, 3'b000);
      chk("rst_stall_vout", valid_out, 1'b0);

      // Five holds then three flushes on the last stage.
      for (int k = 0; k < 5; k++) cyc(1'b0, 3'b100, 3'b000, 8'h30, 1'b1);
      for (int k = 0; k < 3; k++) cyc(1'b0, 3'b000, 3'b100, 8'h31, 1'b1);
`ifdef PIPE_CTRL_SEG_PERF_EN
      chk("perf_hold5", hold_cnt, 32'd5);
      chk("perf_flush3", flush_cnt, 32'd3);
      @(negedge clk);
      force u3.hold_cnt_q = 32'hFFFF_FFFE;
      force u3.flush_cnt_q = 32'hFFFF_FFFE;
      #1;
      release u3.hold_cnt_q;
      release u3.flush_cnt_q;
      m_hc = 64'hFFFF_FFFE; m_fc = 64'hFFFF_FFFE;
      for (int k = 0; k < 3; k++) cyc(1'b0, 3'b100, 3'b000, 8'h32, 1'b1);
      for (int k = 0; k < 3; k++) cyc(1'b0, 3'b000, 3'b100, 8'h33, 1'b1);
      chk("perf_hold_sat", hold_cnt, 32'hFFFF_FFFF);
      chk("perf_flush_sat", flush_cnt, 32'hFFFF_FFFF);
      cyc(1'b1, 3'b000, 3'b000, 8'h00, 1'b0);
      chk("perf_rst", hold_cnt, 32'd0);
`else
      chk("perf_off_hold", hold_cnt, 32'd0);
      chk("perf_off_flush", flush_cnt, 32'd0);
`endif

      // Legacy single-stage MEM/WB behaviour, RESET_VAL = 2'b01.
      bcyc(1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b01, 1'b0);
      bcyc(1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 1'b1);
      bcyc(1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1);
      bcyc(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 2'b01, 1'b0);
      bcyc(1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b11, 1'b1);
      bcyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1);
      bcyc(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0);
      bcyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);

      // Randomized traffic against the model.
      for (int k = 0; k < 800; k++) begin
         logic [D-1:0] rb, rf;
         for (int i = 0; i < D; i++) begin
            rb[i] = ($urandom_range(99) < 20);
            rf[i] = ($urandom_range(99) < 12);
         end
         cyc($urandom_range(99) < 2, rb, rf, W'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
